// File: rtl/core_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : MemArbPkg
//  Purpose : Shared width helpers for the N-port memory arbiter and its
//            tag FIFO.
//  Revision: 1.0  initial release
// ============================================================================
package MemArbPkg;

  localparam int unsigned c_byte_w = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Index width that never collapses to zero bits, so that a single port or
  // a depth-1 FIFO still has a legal one-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Byte-mask width for a given data width.
  function automatic int unsigned wmask_w(input int unsigned data_w);
    return data_w / c_byte_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : arb_tag_fifo
//  Purpose : Small in-order FIFO holding the port index of each in-flight
//            memory request. A pop and a push in the same cycle are accepted
//            even when full, leaving the count unchanged.
//  Revision: 1.0  initial release
// ============================================================================
module arb_tag_fifo
  import MemArbPkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [W-1:0]     r_mem [DEPTH];
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap at DEPTH rather than at a power of the pointer width.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Tag storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping, flushed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : core_mem_arbiter
//  Purpose : Round-robin arbiter sharing one memory port among NUM_PORTS
//            requesters. The grant is held while memory stalls, and responses
//            are routed back in order through a tag FIFO.
//  Revision: 1.0  initial release
// ============================================================================
module core_mem_arbiter
  import MemArbPkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 p_req_valid,
  output logic [NUM_PORTS-1:0]                 p_req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]          p_req_addr,
  input  logic [NUM_PORTS-1:0]                 p_req_we,
  input  logic [NUM_PORTS*DATA_W-1:0]          p_req_wdata,
  input  logic [NUM_PORTS*wmask_w(DATA_W)-1:0] p_req_wmask,
  output logic [NUM_PORTS-1:0]                 p_resp_valid,
  output logic [DATA_W-1:0]                    p_resp_rdata,
  output logic                                 m_req_valid,
  input  logic                                 m_req_ready,
  output logic [ADDR_W-1:0]                    m_req_addr,
  output logic                                 m_req_we,
  output logic [DATA_W-1:0]                    m_req_wdata,
  output logic [wmask_w(DATA_W)-1:0]           m_req_wmask,
  input  logic                                 m_resp_valid,
  input  logic [DATA_W-1:0]                    m_resp_rdata,
  output logic                                 err
);

  localparam int unsigned IDX_W = idx_w(NUM_PORTS);
  localparam int unsigned WM_W  = wmask_w(DATA_W);

  typedef logic [IDX_W-1:0] port_idx_t;

  localparam port_idx_t c_last_port = port_idx_t'(NUM_PORTS - 1);

  port_idx_t   r_rr_ptr;
  port_idx_t   r_lock_port;
  logic        r_lock;
  logic        r_err;

  port_idx_t   w_grant;
  logic        w_grant_valid;
  int unsigned w_cand;
  port_idx_t   w_rr_next;
  logic        w_full;
  logic        w_empty;
  port_idx_t   w_head;
  logic        w_full_block;
  logic        w_hs;
  logic        w_pop;

  // Grant selection: a locked port keeps the grant, otherwise the first
  // requester at or after the round-robin pointer wins.
  always_comb begin
    w_grant       = r_rr_ptr;
    w_grant_valid = 1'b0;
    w_cand        = 0;
    if (r_lock) begin
      w_grant       = r_lock_port;
      w_grant_valid = p_req_valid[r_lock_port];
    end else begin
      for (int unsigned off = 0; off < NUM_PORTS; off++) begin
        w_cand = int'(r_rr_ptr) + off;
        if (w_cand >= NUM_PORTS) w_cand = w_cand - NUM_PORTS;
        if (!w_grant_valid && p_req_valid[port_idx_t'(w_cand)]) begin
          w_grant       = port_idx_t'(w_cand);
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  // A same-cycle response frees a slot, so a full FIFO only blocks when no
  // pop is coming.
  assign w_full_block = w_full && !m_resp_valid;
  assign m_req_valid  = w_grant_valid && !w_full_block && !reset;
  assign w_hs         = m_req_valid && m_req_ready;
  assign w_pop        = m_resp_valid && !w_empty && !reset;
  assign w_rr_next    = (w_grant == c_last_port) ? '0 : w_grant + port_idx_t'(1);

  assign m_req_addr   = p_req_addr[w_grant*ADDR_W +: ADDR_W];
  assign m_req_we     = p_req_we[w_grant];
  assign m_req_wdata  = p_req_wdata[w_grant*DATA_W +: DATA_W];
  assign m_req_wmask  = p_req_wmask[w_grant*WM_W +: WM_W];
  assign p_resp_rdata = m_resp_rdata;
  assign err          = r_err;

  // Per-port strobes: ready to the granted port on handshake, response to the
  // port at the head of the tag FIFO.
  always_comb begin
    p_req_ready  = '0;
    p_resp_valid = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      p_req_ready[i]  = w_hs && (w_grant == port_idx_t'(i));
      p_resp_valid[i] = w_pop && (w_head == port_idx_t'(i));
    end
  end

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_lock_port <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= w_rr_next;
      r_lock   <= 1'b0;
    end else if (m_req_valid) begin
      r_lock      <= 1'b1;
      r_lock_port <= w_grant;
    end
  end

  // Sticky error for a response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (m_resp_valid && w_empty) begin
      r_err <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_hs),
    .pop   (w_pop),
    .din   (w_grant),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_core_mem_arbiter
//  Purpose : Self-checking bench for core_mem_arbiter with a queue-based
//            reference model and randomized requesters and memory.
//  Revision: 1.0  initial release
// ============================================================================
module tb_core_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int MW = DW / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    p_req_valid;
  logic [NP-1:0]    p_req_ready;
  logic [NP*AW-1:0] p_req_addr;
  logic [NP-1:0]    p_req_we;
  logic [NP*DW-1:0] p_req_wdata;
  logic [NP*MW-1:0] p_req_wmask;
  logic [NP-1:0]    p_resp_valid;
  logic [DW-1:0]    p_resp_rdata;
  logic             m_req_valid;
  logic             m_req_ready;
  logic [AW-1:0]    m_req_addr;
  logic             m_req_we;
  logic [DW-1:0]    m_req_wdata;
  logic [MW-1:0]    m_req_wmask;
  logic             m_resp_valid;
  logic [DW-1:0]    m_resp_rdata;
  logic             err;

  core_mem_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
    .p_req_addr(p_req_addr), .p_req_we(p_req_we),
    .p_req_wdata(p_req_wdata), .p_req_wmask(p_req_wmask),
    .p_resp_valid(p_resp_valid), .p_resp_rdata(p_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Requesters: each holds one request until accepted.
  bit            pend   [NP];
  logic [AW-1:0] raddr  [NP];
  logic          rwe    [NP];
  logic [DW-1:0] rwdata [NP];
  logic [MW-1:0] rwmask [NP];

  // Stimulus knobs.
  int req_pct, rdy_pct, resp_pct, spur_pct, lat_min, lat_max;
  bit rr_chk;
  int rr_k;
  logic [NP-1:0] obs_ready;
  int cyc = 0;

  // Memory side: accepted requests awaiting their response.
  logic [DW-1:0] mq_data[$];
  int            mq_due[$];

  // Reference model state.
  int md_rr;
  bit md_lock;
  int md_lock_port;
  int md_tags[$];
  bit md_err;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_00A0;
  endfunction

  task automatic set_req(input int p, input logic [AW-1:0] a);
    pend[p]   = 1'b1;
    raddr[p]  = a;
    rwe[p]    = 1'($urandom_range(1));
    rwdata[p] = $urandom;
    rwmask[p] = MW'($urandom_range(15));
  endtask

  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      p_req_valid[i]           = pend[i];
      p_req_addr[i*AW +: AW]   = raddr[i];
      p_req_we[i]              = rwe[i];
      p_req_wdata[i*DW +: DW]  = rwdata[i];
      p_req_wmask[i*MW +: MW]  = rwmask[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit keep_mem);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      for (int p = 0; p < NP; p++) begin
        pend[p] = 1'b0;
        if ($urandom_range(1) == 1) set_req(p, $urandom);
      end
      drive_ports();
      m_req_ready  = 1'($urandom_range(1));
      m_resp_valid = 1'b0;
      #3;
      check("rst_p_req_ready", p_req_ready, '0);
      check("rst_m_req_valid", m_req_valid, 1'b0);
      check("rst_p_resp_valid", p_resp_valid, '0);
      if (i > 0) check("rst_err", err, 1'b0);
      cyc++;
    end
    md_tags.delete();
    md_rr   = 0;
    md_lock = 1'b0;
    md_err  = 1'b0;
    if (!keep_mem) begin
      mq_data.delete();
      mq_due.delete();
    end
  endtask

  task automatic do_cycle();
    int            g;
    bit            gv, fb, mv, hs, pop;
    logic [NP-1:0] er, ep, want;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NP; i++)
      if (!pend[i] && $urandom_range(99) < req_pct) set_req(i, $urandom);
    drive_ports();
    m_req_ready  = ($urandom_range(99) < rdy_pct);
    m_resp_valid = 1'b0;
    m_resp_rdata = $urandom;
    if (mq_due.size() > 0) begin
      if (mq_due[0] <= cyc && $urandom_range(99) < resp_pct) begin
        m_resp_valid = 1'b1;
        m_resp_rdata = mq_data[0];
      end
    end else if ($urandom_range(99) < spur_pct) begin
      m_resp_valid = 1'b1;
    end
    #3;
    // Expected behaviour for this cycle.
    gv = 1'b0;
    g  = 0;
    if (md_lock) begin
      g  = md_lock_port;
      gv = pend[g];
    end else begin
      for (int k = 0; k < NP; k++) begin
        int c;
        c = (md_rr + k) % NP;
        if (!gv && pend[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
    fb  = (md_tags.size() == MO) && !m_resp_valid;
    mv  = gv && !fb;
    hs  = mv && m_req_ready;
    pop = m_resp_valid && (md_tags.size() > 0);
    er  = '0;
    if (hs) er[g] = 1'b1;
    ep  = '0;
    if (pop) ep[md_tags[0]] = 1'b1;

    check("p_req_ready", p_req_ready, er);
    check("m_req_valid", m_req_valid, mv);
    if (mv) begin
      check("m_req_addr", m_req_addr, raddr[g]);
      check("m_req_we", m_req_we, rwe[g]);
      check("m_req_wdata", m_req_wdata, rwdata[g]);
      check("m_req_wmask", m_req_wmask, rwmask[g]);
    end
    check("p_resp_valid", p_resp_valid, ep);
    if (pop) check("p_resp_rdata", p_resp_rdata, m_resp_rdata);
    check("err", err, md_err);
    if (rr_chk) begin
      want = '0;
      want[rr_k % NP] = 1'b1;
      check("rr_seq", p_req_ready, want);
      rr_k++;
    end
    obs_ready = p_req_ready;

    // Advance the model to the state after the coming clock edge.
    if (m_resp_valid && mq_due.size() > 0) begin
      void'(mq_data.pop_front());
      void'(mq_due.pop_front());
    end
    if (pop) void'(md_tags.pop_front());
    else if (m_resp_valid) md_err = 1'b1;
    if (hs) begin
      md_tags.push_back(g);
      mq_data.push_back(rwe[g] ? DW'($urandom) : mem_data(raddr[g]));
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      pend[g] = 1'b0;
      md_rr   = (g + 1) % NP;
      md_lock = 1'b0;
    end else if (mv) begin
      md_lock      = 1'b1;
      md_lock_port = g;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  initial begin
    int n_obs;
    reset = 1'b1;
    p_req_valid = '0; p_req_addr = '0; p_req_we = '0;
    p_req_wdata = '0; p_req_wmask = '0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0; raddr[i] = '0; rwe[i] = 1'b0; rwdata[i] = '0; rwmask[i] = '0;
    end
    req_pct = 0; rdy_pct = 100; resp_pct = 100; spur_pct = 0;
    lat_min = 1; lat_max = 3; rr_chk = 1'b0; rr_k = 0;
    md_rr = 0; md_lock = 1'b0; md_lock_port = 0; md_err = 1'b0;

    // Reset then idle.
    do_reset(2, 1'b0);
    clear_pend();
    run(3);

    // Round robin with every port requesting and fixed latency 2.
    do_reset(1, 1'b0);
    req_pct = 100; rdy_pct = 100; resp_pct = 100; lat_min = 2; lat_max = 2;
    rr_chk = 1'b1; rr_k = 0;
    run(6);
    rr_chk = 1'b0;
    req_pct = 0;
    run(6);

    // Stall lock on port 1 while port 0 arrives.
    do_reset(1, 1'b0);
    clear_pend();
    req_pct = 0; rdy_pct = 0; lat_min = 1; lat_max = 3;
    set_req(1, 32'h0000_0100);
    do_cycle(); check("stall_addr0", m_req_addr, 32'h100);
    set_req(0, 32'h0000_0200);
    do_cycle(); check("stall_addr1", m_req_addr, 32'h100);
    do_cycle(); check("stall_addr2", m_req_addr, 32'h100);
    rdy_pct = 100;
    do_cycle(); check("stall_accept", p_req_ready, 3'b010);
    do_cycle(); check("after_stall", p_req_ready, 3'b001);
    run(6);

    // Outstanding limit with no responses, then a pop+push cycle.
    do_reset(1, 1'b0);
    clear_pend();
    req_pct = 100; rdy_pct = 100; resp_pct = 0;
    n_obs = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      if (obs_ready != '0) n_obs++;
    end
    check("full_hs_count", n_obs, 4);
    resp_pct = 100;
    do_cycle(); check("full_pop_push", obs_ready != '0, 1'b1);
    resp_pct = 0;
    do_cycle(); check("full_again", m_req_valid, 1'b0);
    req_pct = 0; resp_pct = 100;
    run(10);

    // Spurious response sets a sticky error.
    do_reset(1, 1'b0);
    clear_pend();
    req_pct = 0; spur_pct = 100;
    do_cycle(); check("spur_no_resp", p_resp_valid, '0);
    spur_pct = 0;
    run(3);
    check("err_sticky", err, 1'b1);

    // Reset with two requests outstanding; stale responses flag an error.
    do_reset(1, 1'b0);
    clear_pend();
    req_pct = 100; rdy_pct = 100; resp_pct = 0; lat_min = 1; lat_max = 3;
    run(2);
    do_reset(1, 1'b1);
    clear_pend();
    req_pct = 0; resp_pct = 100;
    run(6);
    check("stray_err", err, 1'b1);
    set_req(1, $urandom);
    set_req(2, $urandom);
    do_cycle(); check("rr_after_reset", obs_ready, 3'b010);
    run(6);

    // Randomized traffic.
    do_reset(2, 1'b0);
    req_pct = 40; rdy_pct = 70; resp_pct = 60; lat_min = 1; lat_max = 4;
    run(3000);
    spur_pct = 3;
    run(500);
    spur_pct = 0; req_pct = 0; resp_pct = 100;
    run(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
